uart_rx: RTL
============

Name: uart_rx

Overview:
UART receiver that consumes the toggling baud_clk from the UART baud generator. Each toggle of baud_clk is one oversample tick (24 MHz / 13 ≈ 16 × 115200 Hz). The block deserialises 8N1 frames from the rx pin and presents each byte on a valid/ready interface to the core-side register/FIFO logic. It flags framing errors and overruns.

Parameters:
DATA_BITS, 8, payload bits per frame, sent LSB first
OVERSAMPLE, 16, ticks per bit period (power of two, ≥ 4)

Ports:
clk  input  1  system clock, 24 MHz
reset_n  input  1  synchronous active-low reset
baud_clk  input  1  oversample toggle from the baud generator, synchronous to clk
rx  input  1  asynchronous serial line, idle high
rx_data  output  DATA_BITS  received byte, stable while rx_valid is high
rx_valid  output  1  byte available
rx_ready  input  1  consumer accepts byte when rx_valid && rx_ready
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: completed byte dropped because rx_valid was still high
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset is sampled on the clk edge when reset_n=0. It forces:
  - state=IDLE, armed=0, all counters=0.
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - rx synchroniser flops=1, baud_clk history flop=0.
  - Reset asserted mid-frame abandons the frame; no error pulses are issued.
- rx passes through a 2-flop synchroniser; rx_s is the output of the second flop.
- tick = baud_clk XOR baud_clk_q, registered one cycle. Both edges of baud_clk are ticks.
- All sampling and counter advance happen only on cycles where tick=1.
- cnt is a log2(OVERSAMPLE)-bit tick counter; bit_idx counts 0..DATA_BITS-1.
- FSM (advances on tick only):
  - IDLE:
    - rx_s=1 → armed=1.
    - armed && rx_s=0 → START, cnt=0.
    - armed=0 prevents a stuck-low line (break) from retriggering repeatedly.
  - START:
    - cnt++.
    - When cnt==OVERSAMPLE/2-1: rx_s=0 → DATA, cnt=0, bit_idx=0.
    - rx_s=1 → IDLE, treated as a glitch; no error pulse.
  - DATA:
    - cnt++.
    - When cnt==OVERSAMPLE-1: shift rx_s in at the MSB of shreg (right shift), cnt=0, bit_idx++.
    - After bit DATA_BITS-1 → STOP.
  - STOP:
    - cnt++.
    - When cnt==OVERSAMPLE-1: rx_s=1 → deliver byte; rx_s=0 → frame_err pulse, byte discarded, armed=0.
    - Both cases → IDLE.
    - Return is at mid-stop-bit, so a back-to-back start edge is caught.
- Deliver (registered outputs, one cycle after the final stop-sample tick):
  - rx_valid=0, or rx_valid && rx_ready in the same cycle → rx_data=shreg, rx_valid=1.
  - Otherwise → overrun=1 for one cycle; new byte dropped; old rx_data and rx_valid unchanged.
- Handshake:
  - rx_valid stays high until a cycle with rx_ready=1; rx_valid falls on the next edge.
  - rx_data must not change while rx_valid=1, except on the same-cycle accept-and-reload above.
- rx_ready while rx_valid=0 has no effect.
- frame_err and overrun are mutually exclusive per frame and never asserted outside the deliver cycle.
- busy is combinational from state.

Test Plan:
- Reset/idle: hold reset_n=0 for 3 clk, rx=1 → all outputs 0; after 20 bit times with rx=1, busy=0 and rx_valid=0.
- Single byte: send 0xA5, 8N1, at 115200 with baud_clk toggling every 13 clk, rx_ready=0 → rx_valid rises within 1 bit time after the stop-bit centre; rx_data=0xA5; rx_valid holds until rx_ready=1, then falls next cycle.
- Back-to-back: send 0x00, 0xFF, 0x55 with no idle gap, rx_ready tied 1 → three valid pulses carrying 0x00, 0xFF, 0x55; no frame_err, no overrun.
- Overrun: send 0x12 then 0x34 with rx_ready=0 → rx_data stays 0x12; one overrun pulse at the second delivery. Repeat with rx_ready=1 in exactly the delivery cycle → rx_data=0x34, no overrun.
- Framing/break: send 0x3C with stop bit=0 → frame_err pulse, rx_valid stays 0. Then hold rx=0 for 5 frames → no further activity until rx returns high; the next valid frame 0x7E is received correctly.
- Glitch and reset: 3-tick low pulse on idle rx → back to IDLE, no outputs. Assert reset_n=0 during bit 4 of a frame → outputs cleared; the next frame 0xC3 is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver driven by the oversample toggle from the baud generator.
// Deserialises frames from rx and hands each byte out on a valid/ready port.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 baud_clk,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state, state_n;
  logic                 rx_meta, rx_s;
  logic                 baud_q, tick;
  logic                 armed, armed_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [BW-1:0]        bit_idx, bit_idx_n;
  logic [DATA_BITS-1:0] shreg;
  logic                 shift_en, stop_ok, stop_bad;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which is what makes the 2-flop chain work.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      baud_q  <= 1'b0;
      tick    <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      baud_q  <= baud_clk;
      tick    <= baud_clk ^ baud_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      armed   <= 1'b0;
      cnt     <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_n;
      armed   <= armed_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_n   = state;
    armed_n   = armed;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shift_en  = 1'b0;
    stop_ok   = 1'b0;
    stop_bad  = 1'b0;
    if (tick) begin
      unique case (state)
        IDLE: begin
          if (armed && !rx_s) begin
            state_n = START;
            cnt_n   = '0;
          end else if (rx_s) begin
            armed_n = 1'b1;
          end
        end
        START: begin
          cnt_n = cnt + 1'b1;
          if (cnt == CNT_HALF) begin
            if (!rx_s) begin
              state_n   = DATA;
              cnt_n     = '0;
              bit_idx_n = '0;
            end else begin
              state_n = IDLE;
            end
          end
        end
        DATA: begin
          cnt_n = cnt + 1'b1;
          if (cnt == CNT_FULL) begin
            shift_en  = 1'b1;
            cnt_n     = '0;
            bit_idx_n = bit_idx + 1'b1;
            if (bit_idx == BIT_LAST) begin
              bit_idx_n = '0;
              state_n   = STOP;
            end
          end
        end
        STOP: begin
          cnt_n = cnt + 1'b1;
          if (cnt == CNT_FULL) begin
            // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start.
            state_n = IDLE;
            cnt_n   = '0;
            if (rx_s) begin
              stop_ok = 1'b1;
            end else begin
              stop_bad = 1'b1;
              armed_n  = 1'b0;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= 1'b0;
      if (shift_en) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (stop_ok) begin
        // A held byte may be replaced only if it is being accepted this cycle.
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
